sequenciador_ciclos: RTL and testbench
======================================

Name: sequenciador_ciclos

Overview:
- Multicycle control FSM for the simple microprocessor core; sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives the 4-bit ALU control vector consumed by the ALU opcode controller, plus PC, IR, memory and register-file strobes.
- Handles variable-latency memory (mem_ready) and multi-cycle ALU ops (MULT/DIVI via ula_start/ula_done).
- A watchdog halts the core on a stalled handshake.

Parameters:
- WAIT_MAX, 255: max cycles spent waiting on mem_ready or ula_done before fault-halt.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR opcode field, valid from DECODE onward.
- opex  in  6  IR extended-op field, register-class ALU ops.
- flag_zero  in  1  ALU zero flag, sampled in EXEC for branches.
- mem_ready  in  1  memory completes the current read/write this cycle.
- ula_done  in  1  multi-cycle ALU result valid this cycle.
- pc_we  out  1  PC write enable.
- pc_sel  out  2  PC source: 0 = pc+1, 1 = jump target, 2 = branch target.
- ir_we  out  1  IR load enable.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- reg_we  out  1  register-file write enable.
- wb_sel  out  1  writeback source: 0 = ALU, 1 = memory data.
- ula_ctrl  out  4  bit0 jump, bit1 branch, bit2 immediate, bit3 address-add (memory).
- ula_start  out  1  one-cycle pulse launching MULT/DIVI.
- halted  out  1  core stopped.
- fault  out  1  watchdog-expiry indicator (sticky).

Behaviour:
- Instruction classes, decoded from opcode:
  - ALU-reg: opcode[5:4] = 00.
  - ALU-imm: opcode[5:4] = 01.
  - MEM: opcode[5:4] = 10; opcode[3] = 0 is load, 1 is store.
  - CTRL: opcode[5:3] = 110; opcode[2] = 0 is jump, 1 is branch-if-zero.
  - HALT: opcode = 6'b111111.
  - Any other opcode is treated as HALT, with fault = 0.
- Multi-cycle op: ALU-reg with opex[4:0] in {2, 3}, or ALU-imm with opcode[3:0] in {2, 3}.
- States: FETCH, DECODE, EXEC, WAIT_ULA, MEM, WB, HALT.
- Reset (async): state = FETCH, wait counter = 0, ula_ctrl = 0, halted = 0, fault = 0. While rst is high, every output is 0; mem_rd is gated by rst.
- FETCH:
  - mem_rd = 1.
  - On mem_ready: ir_we = 1, pc_we = 1, pc_sel = 0, go to DECODE. Otherwise stay.
- DECODE:
  - Register ula_ctrl from the class: bit2 for ALU-imm, bit3 for MEM, bit0 for jump, bit1 for branch.
  - HALT class goes to HALT; all other classes go to EXEC.
- EXEC:
  - Jump: pc_we = 1, pc_sel = 1, go to FETCH.
  - Branch: if flag_zero, pc_we = 1 and pc_sel = 2; go to FETCH either way.
  - ALU, multi-cycle: ula_start = 1 for exactly this cycle, go to WAIT_ULA.
  - ALU, single-cycle: go to WB.
  - MEM: go to MEM.
- WAIT_ULA: on ula_done go to WB; otherwise stay.
- MEM:
  - Load: mem_rd = 1; on mem_ready go to WB with wb_sel latched to 1.
  - Store: mem_wr = 1; on mem_ready go to FETCH. No reg_we for stores.
- WB: reg_we = 1 for exactly one cycle, wb_sel held, go to FETCH. wb_sel = 0 for ALU instructions.
- HALT:
  - halted = 1; all strobes 0.
  - Sticky until rst.
- ula_ctrl:
  - Holds its registered value from DECODE until the next FETCH.
  - Reads 0 in FETCH and DECODE.
- Watchdog:
  - The counter clears on every state change and increments each cycle spent in FETCH, MEM or WAIT_ULA while the awaited handshake is low.
  - When the count reaches WAIT_MAX with the handshake still low, the next state is HALT and fault is set to 1.
  - A handshake arriving on the same cycle the limit is reached wins: the transition proceeds normally with no fault.
- Handshakes:
  - mem_ready or ula_done asserted in any state other than the one awaiting it is ignored.
  - A simultaneous mem_ready and ula_done has no cross-effect.
- Reset mid-instruction: immediate return to FETCH with all strobes dropped. No partial reg_we or mem_wr may survive past rst assertion.
- Throughput: 4 cycles minimum for a single-cycle ALU op with zero-wait memory (FETCH, DECODE, EXEC, WB); 3 cycles for jump/branch.

Decomposition:
- Shared package:
  - state encodings (3 bits);
  - class codes;
  - ula_ctrl bit indices;
  - pc_sel values;
  - opcode constants HALT_OP, MULT = 2, DIVI = 3.
- One natural sub-module: decodificador_classe. It is purely combinational, mapping opcode/opex to class, is_load, is_branch and is_multi. It is reused by the hazard logic later.

Test Plan:
- Reset, then ALU-reg add (opcode 000000, opex 000000) with mem_ready held high -> ir_we in cycle 1, reg_we in cycle 4, ula_ctrl = 0000, wb_sel = 0.
- ALU-imm MULT (opcode 010010), ula_done asserted 5 cycles after ula_start -> single ula_start pulse, ula_ctrl = 0100, reg_we one cycle after ula_done.
- Load (opcode 100000) with mem_ready delayed 3 cycles in MEM -> mem_rd held 4 cycles, ula_ctrl = 1000, wb_sel = 1 with reg_we. Store (opcode 101000) -> mem_wr, no reg_we.
- Branch (opcode 110100) with flag_zero = 1 -> pc_we with pc_sel = 2; with flag_zero = 0 -> no pc_we in EXEC. Jump (opcode 110000) -> pc_sel = 1.
- WAIT_MAX = 4, mem_ready never asserted in FETCH -> HALT after 4 wait cycles with fault = 1, halted = 1. mem_ready arriving on the limit cycle -> no fault.
- rst pulsed during WB, and separately during HALT -> reg_we drops asynchronously, state FETCH, halted = 0, fault = 0.

Source files
------------

// File: rtl/sequenciador_ciclos_pkg.sv
// Shared types and constants for the multicycle control sequencer and its
// instruction-class decoder.
package sequenciador_ciclos_pkg;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExec    = 3'd2,
        StWaitUla = 3'd3,
        StMem     = 3'd4,
        StWb      = 3'd5,
        StHalt    = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ClsAluReg  = 3'd0,
        ClsAluImm  = 3'd1,
        ClsMem     = 3'd2,
        ClsCtrl    = 3'd3,
        ClsHalt    = 3'd4,
        ClsIllegal = 3'd5
    } class_e;

    localparam int unsigned UlaJump   = 0;
    localparam int unsigned UlaBranch = 1;
    localparam int unsigned UlaImm    = 2;
    localparam int unsigned UlaAddr   = 3;

    localparam logic [1:0] PcSelInc    = 2'd0;
    localparam logic [1:0] PcSelJump   = 2'd1;
    localparam logic [1:0] PcSelBranch = 2'd2;

    localparam logic [5:0] HALT_OP = 6'b111111;
    localparam logic [4:0] MULT    = 5'd2;
    localparam logic [4:0] DIVI    = 5'd3;

    function automatic logic [3:0] ula_ctrl_of(input class_e cls, input logic is_branch);
        logic [3:0] r;
        r = '0;
        case (cls)
            ClsAluImm: r[UlaImm]  = 1'b1;
            ClsMem:    r[UlaAddr] = 1'b1;
            ClsCtrl: begin
                if (is_branch) r[UlaBranch] = 1'b1;
                else           r[UlaJump]   = 1'b1;
            end
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sequenciador_ciclos_decodificador_classe.sv
// Combinational opcode/opex classifier; shared with the hazard logic.
module decodificador_classe
    import sequenciador_ciclos_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] opex_i,
    output class_e     cls_o,
    output logic       is_load_o,
    output logic       is_branch_o,
    output logic       is_multi_o
);

    logic unused_opex;
    assign unused_opex = opex_i[5];

    always_comb begin
        cls_o       = ClsIllegal;
        is_load_o   = 1'b0;
        is_branch_o = 1'b0;
        is_multi_o  = 1'b0;
        unique case (opcode_i[5:4])
            2'b00: begin
                cls_o      = ClsAluReg;
                is_multi_o = (opex_i[4:0] == MULT) || (opex_i[4:0] == DIVI);
            end
            2'b01: begin
                cls_o      = ClsAluImm;
                is_multi_o = (opcode_i[3:0] == MULT[3:0]) || (opcode_i[3:0] == DIVI[3:0]);
            end
            2'b10: begin
                cls_o     = ClsMem;
                is_load_o = ~opcode_i[3];
            end
            2'b11: begin
                if (!opcode_i[3]) begin
                    cls_o       = ClsCtrl;
                    is_branch_o = opcode_i[2];
                end else if (opcode_i == HALT_OP) begin
                    cls_o = ClsHalt;
                end else begin
                    cls_o = ClsIllegal;
                end
            end
            default: cls_o = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/sequenciador_ciclos.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with a handshake watchdog.
// Strobes are combinational from state and handshakes, all gated by rst.
module sequenciador_ciclos
    import sequenciador_ciclos_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] opex,
    input  logic       flag_zero,
    input  logic       mem_ready,
    input  logic       ula_done,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       ir_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_we,
    output logic       wb_sel,
    output logic [3:0] ula_ctrl,
    output logic       ula_start,
    output logic       halted,
    output logic       fault
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         ula_ctrl_q, ula_ctrl_d;
    logic               wb_sel_q, wb_sel_d;
    logic               fault_q, fault_d;

    class_e cls;
    logic   is_load, is_branch, is_multi;

    logic       pc_we_c, ir_we_c, mem_rd_c, mem_wr_c, reg_we_c, ula_start_c;
    logic [1:0] pc_sel_c;
    logic       awaiting, handshake, at_limit;

    decodificador_classe u_dec (
        .opcode_i    (opcode),
        .opex_i      (opex),
        .cls_o       (cls),
        .is_load_o   (is_load),
        .is_branch_o (is_branch),
        .is_multi_o  (is_multi)
    );

    always_comb begin
        awaiting  = (state_q == StFetch) || (state_q == StMem) || (state_q == StWaitUla);
        handshake = (state_q == StWaitUla) ? ula_done : mem_ready;
        at_limit  = (cnt_q == CNT_W'(WAIT_MAX - 1));
    end

    always_comb begin
        state_d     = state_q;
        ula_ctrl_d  = ula_ctrl_q;
        wb_sel_d    = wb_sel_q;
        fault_d     = fault_q;
        pc_we_c     = 1'b0;
        pc_sel_c    = PcSelInc;
        ir_we_c     = 1'b0;
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        reg_we_c    = 1'b0;
        ula_start_c = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_rd_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ula_ctrl_d = ula_ctrl_of(cls, is_branch);
                state_d    = (cls == ClsHalt || cls == ClsIllegal) ? StHalt : StExec;
            end
            StExec: begin
                unique case (cls)
                    ClsCtrl: begin
                        if (!is_branch) begin
                            pc_we_c  = 1'b1;
                            pc_sel_c = PcSelJump;
                        end else if (flag_zero) begin
                            pc_we_c  = 1'b1;
                            pc_sel_c = PcSelBranch;
                        end
                        state_d = StFetch;
                    end
                    ClsAluReg, ClsAluImm: begin
                        ula_start_c = is_multi;
                        state_d     = is_multi ? StWaitUla : StWb;
                    end
                    ClsMem:  state_d = StMem;
                    default: state_d = StHalt;
                endcase
            end
            StWaitUla: begin
                if (ula_done) state_d = StWb;
            end
            StMem: begin
                mem_rd_c = is_load;
                mem_wr_c = ~is_load;
                if (mem_ready) begin
                    if (is_load) begin
                        wb_sel_d = 1'b1;
                        state_d  = StWb;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                reg_we_c = 1'b1;
                state_d  = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase

        // A handshake on the limit cycle takes the normal path above.
        if (awaiting && !handshake && at_limit) begin
            state_d = StHalt;
            fault_d = 1'b1;
        end

        if (state_d != state_q)           cnt_d = '0;
        else if (awaiting && !handshake)  cnt_d = cnt_q + 1'b1;
        else                              cnt_d = cnt_q;

        if (state_d == StFetch || state_d == StHalt) ula_ctrl_d = '0;
        if (state_d == StFetch)                      wb_sel_d   = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            cnt_q      <= '0;
            ula_ctrl_q <= '0;
            wb_sel_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ula_ctrl_q <= ula_ctrl_d;
            wb_sel_q   <= wb_sel_d;
            fault_q    <= fault_d;
        end
    end

    assign pc_we     = pc_we_c & ~rst;
    assign pc_sel    = rst ? PcSelInc : pc_sel_c;
    assign ir_we     = ir_we_c & ~rst;
    assign mem_rd    = mem_rd_c & ~rst;
    assign mem_wr    = mem_wr_c & ~rst;
    assign reg_we    = reg_we_c & ~rst;
    assign ula_start = ula_start_c & ~rst;
    assign wb_sel    = wb_sel_q & ~rst;
    assign ula_ctrl  = rst ? 4'b0000 : ula_ctrl_q;
    assign halted    = (state_q == StHalt) & ~rst;
    assign fault     = fault_q & ~rst;

endmodule

// File: tb/tb_sequenciador_ciclos.sv
// Per-cycle vector bench: rows are driven and queued, then popped and compared
// against a packed snapshot of the outputs on the falling edge.
module tb_sequenciador_ciclos;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, opex;
    logic       flag_zero, mem_ready, ula_done;

    logic       a_pc_we, a_ir_we, a_mem_rd, a_mem_wr, a_reg_we, a_wb_sel, a_start, a_halted, a_fault;
    logic [1:0] a_pc_sel;
    logic [3:0] a_ula;
    logic       b_pc_we, b_ir_we, b_mem_rd, b_mem_wr, b_reg_we, b_wb_sel, b_start, b_halted, b_fault;
    logic [1:0] b_pc_sel;
    logic [3:0] b_ula;
    logic [14:0] out_a, out_b;

    always #5 clk = ~clk;

    sequenciador_ciclos u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .opex(opex), .flag_zero(flag_zero),
        .mem_ready(mem_ready), .ula_done(ula_done), .pc_we(a_pc_we), .pc_sel(a_pc_sel),
        .ir_we(a_ir_we), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .reg_we(a_reg_we),
        .wb_sel(a_wb_sel), .ula_ctrl(a_ula), .ula_start(a_start), .halted(a_halted),
        .fault(a_fault)
    );

    sequenciador_ciclos #(.WAIT_MAX(4), .CNT_W(3)) u_dut_wd (
        .clk(clk), .rst(rst), .opcode(opcode), .opex(opex), .flag_zero(flag_zero),
        .mem_ready(mem_ready), .ula_done(ula_done), .pc_we(b_pc_we), .pc_sel(b_pc_sel),
        .ir_we(b_ir_we), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .reg_we(b_reg_we),
        .wb_sel(b_wb_sel), .ula_ctrl(b_ula), .ula_start(b_start), .halted(b_halted),
        .fault(b_fault)
    );

    assign out_a = {a_pc_we, a_pc_sel, a_ir_we, a_mem_rd, a_mem_wr, a_reg_we, a_wb_sel,
                    a_ula, a_start, a_halted, a_fault};
    assign out_b = {b_pc_we, b_pc_sel, b_ir_we, b_mem_rd, b_mem_wr, b_reg_we, b_wb_sel,
                    b_ula, b_start, b_halted, b_fault};

    localparam logic [14:0] PCWE  = 15'h4000;
    localparam logic [14:0] SELJ  = 15'h1000;
    localparam logic [14:0] SELB  = 15'h2000;
    localparam logic [14:0] IRWE  = 15'h0800;
    localparam logic [14:0] MRD   = 15'h0400;
    localparam logic [14:0] MWR   = 15'h0200;
    localparam logic [14:0] REGWE = 15'h0100;
    localparam logic [14:0] WBS   = 15'h0080;
    localparam logic [14:0] START = 15'h0004;
    localparam logic [14:0] HLT   = 15'h0002;
    localparam logic [14:0] FLT   = 15'h0001;
    localparam logic [14:0] NONE  = 15'h0000;

    function automatic logic [14:0] uc(input logic [3:0] u);
        return {8'b0, u, 3'b0};
    endfunction

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  ox;
        logic        fz;
        logic        mr;
        logic        ud;
        logic        wd;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    vec_t cur;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [14:0] got, input logic [14:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk(cur.name, cur.wd ? out_b : out_a, cur.exp);
        end
    end

    task automatic add(input string n, input logic [5:0] op, input logic [5:0] ox,
                       input logic fz, input logic mr, input logic ud, input logic wd,
                       input logic [14:0] exp);
        vec_t v;
        v.name = n; v.op = op; v.ox = ox; v.fz = fz; v.mr = mr; v.ud = ud; v.wd = wd;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    // Drive one row for the current cycle, queue its expectation, advance.
    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            opcode    = tbl[i].op;
            opex      = tbl[i].ox;
            flag_zero = tbl[i].fz;
            mem_ready = tbl[i].mr;
            ula_done  = tbl[i].ud;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    task automatic pulse_rst(input string n, input logic wd);
        rst = 1'b1;
        #1;
        chk(n, wd ? out_b : out_a, NONE);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; opcode = '0; opex = '0; flag_zero = 1'b1; mem_ready = 1'b1; ula_done = 1'b1;
        #12;
        chk("reset_out_a", out_a, NONE);
        chk("reset_out_b", out_b, NONE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        add("add_fetch",   6'o00, 6'o00, 0, 1, 0, 0, MRD | IRWE | PCWE);
        add("add_decode",  6'o00, 6'o00, 0, 1, 0, 0, NONE);
        add("add_exec",    6'o00, 6'o00, 0, 1, 0, 0, NONE);
        add("add_wb",      6'o00, 6'o00, 0, 1, 0, 0, REGWE);
        add("mult_fetch",  6'h12, 6'o00, 0, 1, 0, 0, MRD | IRWE | PCWE);
        add("mult_decode", 6'h12, 6'o00, 0, 1, 0, 0, NONE);
        add("mult_exec",   6'h12, 6'o00, 0, 1, 0, 0, START | uc(4'b0100));
        for (int i = 0; i < 4; i++) add("mult_wait", 6'h12, 6'o00, 0, 1, 0, 0, uc(4'b0100));
        add("mult_done",   6'h12, 6'o00, 0, 1, 1, 0, uc(4'b0100));
        add("mult_wb",     6'h12, 6'o00, 0, 1, 0, 0, REGWE | uc(4'b0100));
        add("ld_fetch",    6'h20, 6'o00, 0, 1, 0, 0, MRD | IRWE | PCWE);
        add("ld_decode",   6'h20, 6'o00, 0, 0, 0, 0, NONE);
        add("ld_exec",     6'h20, 6'o00, 0, 0, 0, 0, uc(4'b1000));
        for (int i = 0; i < 3; i++) add("ld_mem_wait", 6'h20, 6'o00, 0, 0, 1, 0, MRD | uc(4'b1000));
        add("ld_mem_rdy",  6'h20, 6'o00, 0, 1, 0, 0, MRD | uc(4'b1000));
        add("ld_wb",       6'h20, 6'o00, 0, 0, 0, 0, REGWE | WBS | uc(4'b1000));
        add("st_fetch",    6'h28, 6'o00, 0, 1, 0, 0, MRD | IRWE | PCWE);
        add("st_decode",   6'h28, 6'o00, 0, 0, 0, 0, NONE);
        add("st_exec",     6'h28, 6'o00, 0, 0, 0, 0, uc(4'b1000));
        add("st_mem_wait", 6'h28, 6'o00, 0, 0, 0, 0, MWR | uc(4'b1000));
        add("st_mem_rdy",  6'h28, 6'o00, 0, 1, 0, 0, MWR | uc(4'b1000));
        add("st_refetch",  6'h28, 6'o00, 0, 0, 0, 0, MRD);
        add("bz1_fetch",   6'h34, 6'o00, 1, 1, 0, 0, MRD | IRWE | PCWE);
        add("bz1_decode",  6'h34, 6'o00, 1, 1, 0, 0, NONE);
        add("bz1_exec",    6'h34, 6'o00, 1, 1, 0, 0, PCWE | SELB | uc(4'b0010));
        add("bz0_fetch",   6'h34, 6'o00, 0, 1, 0, 0, MRD | IRWE | PCWE);
        add("bz0_decode",  6'h34, 6'o00, 0, 1, 0, 0, NONE);
        add("bz0_exec",    6'h34, 6'o00, 0, 1, 0, 0, uc(4'b0010));
        add("jmp_fetch",   6'h30, 6'o00, 0, 1, 0, 0, MRD | IRWE | PCWE);
        add("jmp_decode",  6'h30, 6'o00, 0, 1, 0, 0, NONE);
        add("jmp_exec",    6'h30, 6'o00, 0, 1, 0, 0, PCWE | SELJ | uc(4'b0001));
        add("divi_fetch",  6'h00, 6'h03, 0, 1, 0, 0, MRD | IRWE | PCWE);
        add("divi_decode", 6'h00, 6'h03, 0, 1, 0, 0, NONE);
        add("divi_exec",   6'h00, 6'h03, 0, 1, 1, 0, START);
        add("divi_wait",   6'h00, 6'h03, 0, 1, 0, 0, NONE);
        add("divi_done",   6'h00, 6'h03, 0, 1, 1, 0, NONE);
        add("divi_wb",     6'h00, 6'h03, 0, 1, 0, 0, REGWE);
        add("ill_fetch",   6'h38, 6'o00, 0, 1, 0, 0, MRD | IRWE | PCWE);
        add("ill_decode",  6'h38, 6'o00, 0, 1, 0, 0, NONE);
        add("ill_halt",    6'h38, 6'o00, 0, 1, 1, 0, HLT);
        add("ill_sticky",  6'h38, 6'o00, 0, 1, 1, 0, HLT);
        run_tbl();
        pulse_rst("halt_rst", 0);

        add("rwb_fetch",   6'o00, 6'o00, 0, 1, 0, 0, MRD | IRWE | PCWE);
        add("rwb_decode",  6'o00, 6'o00, 0, 1, 0, 0, NONE);
        add("rwb_exec",    6'o00, 6'o00, 0, 1, 0, 0, NONE);
        run_tbl();
        #2;
        chk("rwb_reg_we_on", out_a, REGWE);
        pulse_rst("rwb_rst_drop", 0);
        add("rwb_refetch", 6'o00, 6'o00, 0, 0, 0, 0, MRD);
        run_tbl();
        pulse_rst("wd_pre_rst", 1);

        for (int i = 0; i < 4; i++) add("wd_wait", 6'o00, 6'o00, 0, 0, 0, 1, MRD);
        add("wd_halt",     6'o00, 6'o00, 0, 0, 0, 1, HLT | FLT);
        add("wd_sticky",   6'o00, 6'o00, 0, 1, 0, 1, HLT | FLT);
        run_tbl();
        pulse_rst("wd_halt_rst", 1);

        for (int i = 0; i < 3; i++) add("lim_wait", 6'o00, 6'o00, 0, 0, 0, 1, MRD);
        add("lim_rdy",     6'o00, 6'o00, 0, 1, 0, 1, MRD | IRWE | PCWE);
        add("lim_decode",  6'o00, 6'o00, 0, 0, 0, 1, NONE);
        add("lim_exec",    6'o00, 6'o00, 0, 0, 0, 1, NONE);
        add("lim_wb",      6'o00, 6'o00, 0, 0, 0, 1, REGWE);
        add("lim_refetch", 6'o00, 6'o00, 0, 0, 0, 1, MRD);
        run_tbl();

        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
